// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared constants and repeat-FSM state encoding for the
//               multi-channel push-button pulser.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

   // Pulse source selection
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_BOTH = 2;

   // Auto-repeat state encoding
   typedef enum logic [1:0] {
      RP_IDLE   = 2'd0,
      RP_DELAY  = 2'd1,
      RP_REPEAT = 2'd2
   } rp_state_e;

   // Larger of two integers, used to size the shared repeat counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pb_channel.sv
`default_nettype none
// ============================================================================
// Module      : pb_channel
// Description : One push-button channel: two-flop synchroniser, hold-count
//               debounce, selectable edge pulse and optional auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_channel
   import button_pkg::*;
#(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int EDGE_MODE     = EDGE_RISE,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_i,
   output logic level_o,
   output logic pulse_o,
   output logic repeating_o
);

   localparam int DB_W   = $clog2(DB_CYCLES);
   localparam int RP_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int RP_W   = $clog2(RP_MAX);

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [RP_W-1:0] RD_LAST  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_LAST  = RP_W'(REPEAT_PERIOD - 1);
   localparam logic [RP_W-1:0] RP_SAT   = '1;

   localparam logic RISE_PULSE = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
   localparam logic FALL_PULSE = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);
   // Repeat only makes sense when presses themselves produce pulses
   localparam logic RP_ACTIVE  = (REPEAT_EN == 1) && (EDGE_MODE != EDGE_FALL);

   logic            s1_q;
   logic            s2_q;
   logic            level_q;
   logic            level_d;
   logic [DB_W-1:0] db_cnt_q;
   logic [DB_W-1:0] db_cnt_d;
   logic            pulse_q;
   logic            repeating_q;
   logic [RP_W-1:0] rp_cnt_q;
   rp_state_e       rp_state_q;

   logic            w_rise_acc;
   logic            w_fall_acc;

   // Two-flop synchroniser for the asynchronous button level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= pb_i;
         s2_q <= s1_q;
      end
   end

   // Debounce: count consecutive cycles of disagreement, accept on the last one
   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (s2_q != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   assign w_rise_acc = level_d & ~level_q;
   assign w_fall_acc = ~level_d & level_q;

   // Debounced level and hold counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         level_q  <= level_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Edge pulse generation and auto-repeat FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_state_q  <= RP_IDLE;
         rp_cnt_q    <= '0;
         repeating_q <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         pulse_q <= (w_rise_acc && RISE_PULSE) || (w_fall_acc && FALL_PULSE);
         if (!RP_ACTIVE) begin
            rp_state_q  <= RP_IDLE;
            rp_cnt_q    <= '0;
            repeating_q <= 1'b0;
         end else begin
            case (rp_state_q)
               RP_IDLE: begin
                  repeating_q <= 1'b0;
                  rp_cnt_q    <= '0;
                  if (w_rise_acc) begin
                     rp_state_q <= RP_DELAY;
                  end
               end
               RP_DELAY: begin
                  // A release always wins, so no repeat pulse can meet an edge pulse
                  if (w_fall_acc) begin
                     rp_state_q <= RP_IDLE;
                     rp_cnt_q   <= '0;
                  end else if (rp_cnt_q == RD_LAST) begin
                     pulse_q     <= 1'b1;
                     rp_cnt_q    <= '0;
                     repeating_q <= 1'b1;
                     rp_state_q  <= RP_REPEAT;
                  end else if (rp_cnt_q != RP_SAT) begin
                     rp_cnt_q <= rp_cnt_q + RP_W'(1);
                  end
               end
               RP_REPEAT: begin
                  if (w_fall_acc) begin
                     rp_state_q  <= RP_IDLE;
                     rp_cnt_q    <= '0;
                     repeating_q <= 1'b0;
                  end else if (rp_cnt_q == RP_LAST) begin
                     pulse_q  <= 1'b1;
                     rp_cnt_q <= '0;
                  end else if (rp_cnt_q != RP_SAT) begin
                     rp_cnt_q <= rp_cnt_q + RP_W'(1);
                  end
               end
               default: begin
                  rp_state_q  <= RP_IDLE;
                  rp_cnt_q    <= '0;
                  repeating_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign level_o     = level_q;
   assign pulse_o     = pulse_q;
   assign repeating_o = repeating_q;

endmodule
`default_nettype wire

// File: rtl/button_pulser.sv
`default_nettype none
// ============================================================================
// Module      : button_pulser
// Description : N_CH independent debounced push-button pulsers with optional
//               auto-repeat, feeding the game control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_pulser
   import button_pkg::*;
#(
   parameter int N_CH          = 5,
   parameter int DB_CYCLES     = 1_000_000,
   parameter int EDGE_MODE     = EDGE_RISE,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] pb,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] pulse,
   output logic [N_CH-1:0] repeating
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pb_channel #(
         .DB_CYCLES     (DB_CYCLES),
         .EDGE_MODE     (EDGE_MODE),
         .REPEAT_EN     (REPEAT_EN),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .pb_i        (pb[g]),
         .level_o     (level[g]),
         .pulse_o     (pulse[g]),
         .repeating_o (repeating[g])
      );
   end

endmodule
`default_nettype wire
